cell_stim_gen: RTL and testbench
================================

Name: cell_stim_gen

Overview:
- Parametrised next-generation stimulus engine for the cell tester.
- Drives one of CHANNELS target-cell inputs with a square wave at clk/2^(div+1).
- Three run modes: continuous, counted burst on trigger, single-step on trigger.
- Sits between the pin-level control inputs and the target-cell drive buses, and exposes busy/done status and a pulse counter for readback.

Parameters:
- CHANNELS, 8, number of target-cell drive lines.
- SRC_W, 3, width of channel select; must satisfy 2^SRC_W >= CHANNELS.
- DIV_W, 3, width of divider exponent; half-period = 2^div cycles.
- BURST_W, 8, width of burst length in pulses.
- CNT_W, 16, width of pulse counter.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  0=OFF, 1=CONT, 2=BURST, 3=STEP.
- trigger  in  1  asynchronous pin; synchronised internally.
- div  in  DIV_W  divider exponent.
- source  in  SRC_W  channel select.
- burst_len  in  BURST_W  pulses per burst.
- clr_cnt  in  1  synchronous clear of pulse_cnt.
- drive  out  CHANNELS  target drive; only the selected bit is ever non-zero.
- busy  out  1  high while FSM is in RUN.
- done  out  1  one-cycle pulse at burst completion.
- pulse_cnt  out  CNT_W  count of completed high phases; wraps.

Behaviour:
- Reset: state=IDLE; drive=0, busy=0, done=0, pulse_cnt=0; wave, prescaler, sync flops and latches all 0.
- Trigger path:
  - Two-flop synchroniser, then rising-edge detect. trig_pulse is a one-cycle pulse, 3 clk edges after the pin rises.
  - Edges arriving while in RUN are dropped; there is no queueing.
- Prescaler:
  - pre counts 0..2^div_l-1. tick is asserted when pre==2^div_l-1, and pre then wraps to 0.
  - pre is cleared on RUN entry. The first toggle occurs 2^div_l cycles after entry.
- On RUN entry, div_l and src_l latch div and source. Changes to div/source during RUN are ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN when mode==CONT, or when mode==BURST and trig_pulse. For BURST, remaining loads burst_len.
  - BURST with burst_len==0: IDLE->DONE directly; done pulses, no toggles.
  - RUN: wave toggles on each tick. In BURST, remaining decrements on each high->low toggle. Reaching 0 goes to DONE, with the wave already low.
  - RUN->IDLE when mode changes away from the mode that entered RUN. wave is forced to 0 in the same edge, with no done pulse.
  - DONE: done=1 for exactly one cycle, then IDLE. Retriggering needs a new edge.
- STEP mode:
  - FSM stays in IDLE.
  - Each trig_pulse toggles wave immediately, with source sampled at that pulse.
  - busy stays 0.
  - Leaving STEP forces wave to 0.
- OFF mode: wave=0, FSM in IDLE.
- drive is registered: drive[i] = wave & (src_l==i). If src_l >= CHANNELS, drive=0 but counting proceeds.
- pulse_cnt:
  - Increments on every wave high->low transition in any mode, including a forced low at mode change. Wraps at 2^CNT_W.
  - clr_cnt has priority over a simultaneous increment (result 0).
- Async rst mid-burst returns everything to reset values on the next evaluation. No done is issued.

Decomposition:
- Package cell_stim_pkg holds:
  - mode enum (MODE_OFF, MODE_CONT, MODE_BURST, MODE_STEP).
  - FSM state enum (ST_IDLE, ST_RUN, ST_DONE).
  - Shared localparam for synchroniser depth (2).
- Sub-module edge_sync holds the 2-flop synchroniser plus rising-edge detect, with async active-high reset. It is reusable by future tester blocks.
- Prescaler, FSM and counter stay in cell_stim_gen.

Test Plan:
- Reset release, then mode=CONT, div=0, source=2:
  - drive = 0x04/0x00 alternating every cycle, starting 1 cycle after RUN entry. busy=1.
  - After 10 cycles, pulse_cnt=5 (±1 by phase).
- mode=BURST, div=2, source=5, burst_len=3, single trigger:
  - drive[5] gives 3 pulses, each 4 high / 4 low cycles.
  - done pulses once for 1 cycle, busy falls, pulse_cnt=3.
  - A second trigger mid-burst has no effect.
- mode=BURST, burst_len=0, trigger: done pulses once, drive stays 0x00, pulse_cnt unchanged.
- mode=STEP, source=7, four trigger edges spaced 10 cycles apart:
  - drive[7] toggles high/low/high/low, each change 3 cycles after its edge.
  - pulse_cnt=2, busy never 1.
- CONT with source=1, drive high; switch mode to OFF:
  - drive=0x00 next cycle, pulse_cnt increments by 1, no done.
  - Then source=9 with CHANNELS=8: drive stays 0 while pulse_cnt advances.
- Async rst asserted mid-burst, with clr_cnt and an increment coinciding beforehand:
  - All outputs 0 immediately after reset, no done pulse.
  - The earlier coincident clr_cnt+increment cycle yields pulse_cnt=0.

Source files
------------

// File: rtl/cell_stim_pkg.sv
// Shared types for the cell tester stimulus engine:
// run-mode and FSM state enums, synchroniser depth.
package cell_stim_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_STEP  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser plus rising-edge detect for an async pin.
// Ports: clk, rst (async high), din (async pin), pulse (1-cycle rise).
module edge_sync
  import cell_stim_pkg::*;
#(
  parameter int DEPTH = SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [DEPTH-1:0] sync_q;
  logic             last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], din};
      last_q <= sync_q[DEPTH-1];
    end
  end

  assign pulse = sync_q[DEPTH-1] & ~last_q;

endmodule

// File: rtl/cell_stim_gen.sv
// Square-wave stimulus engine: continuous, counted burst, single step.
// Ports: clk, rst, mode, trigger, div, source, burst_len, clr_cnt
//        -> drive (one-hot wave), busy, done, pulse_cnt.
module cell_stim_gen
  import cell_stim_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SRC_W    = 3,
  parameter int DIV_W    = 3,
  parameter int BURST_W  = 8,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               trigger,
  input  logic [DIV_W-1:0]   div,
  input  logic [SRC_W-1:0]   source,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               clr_cnt,
  output logic [CHANNELS-1:0] drive,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pulse_cnt
);

  // Largest half-period is 2^(2^DIV_W-1) cycles.
  localparam int PRE_W = (1 << DIV_W) - 1;
  localparam logic [PRE_W-1:0] PRE_ONES = '1;

  mode_e              mode_in;
  mode_e              run_mode_q, run_mode_d;
  state_e             state_q, state_d;
  logic               wave_q, wave_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [PRE_W-1:0]   pre_max;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [CHANNELS-1:0] drive_q, drive_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trig_pulse;
  logic               tick;
  logic               fall;

  edge_sync #(
    .DEPTH(SYNC_DEPTH)
  ) u_trig (
    .clk  (clk),
    .rst  (rst),
    .din  (trigger),
    .pulse(trig_pulse)
  );

  assign mode_in = mode_e'(mode);
  assign pre_max = ~(PRE_ONES << div_q);
  assign tick    = (pre_q == pre_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_mode_q <= MODE_OFF;
      wave_q     <= 1'b0;
      pre_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      src_q      <= '0;
      drive_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      wave_q     <= wave_d;
      pre_q      <= pre_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      src_q      <= src_d;
      drive_q    <= drive_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    wave_d     = wave_q;
    pre_d      = pre_q;
    rem_d      = rem_q;
    div_d      = div_q;
    src_d      = src_q;
    unique case (state_q)
      ST_IDLE: begin
        // Only STEP may hold the wave high while idle.
        wave_d = 1'b0;
        pre_d  = '0;
        if (mode_in == MODE_CONT) begin
          state_d    = ST_RUN;
          run_mode_d = mode_in;
          div_d      = div;
          src_d      = source;
        end else if (mode_in == MODE_BURST && trig_pulse) begin
          if (burst_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_RUN;
            run_mode_d = mode_in;
            div_d      = div;
            src_d      = source;
            rem_d      = burst_len;
          end
        end else if (mode_in == MODE_STEP) begin
          wave_d = wave_q ^ trig_pulse;
          if (trig_pulse) src_d = source;
        end
      end
      ST_RUN: begin
        if (mode_in != run_mode_q) begin
          state_d = ST_IDLE;
          wave_d  = 1'b0;
        end else begin
          pre_d = tick ? '0 : pre_q + PRE_W'(1);
          if (tick) begin
            wave_d = ~wave_q;
            // A burst pulse ends on its falling toggle.
            if (run_mode_q == MODE_BURST && wave_q) begin
              rem_d = rem_q - BURST_W'(1);
              if (rem_q == BURST_W'(1)) state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wave_d  = 1'b0;
      end
    endcase
  end

  assign fall = wave_q & ~wave_d;

  always_comb begin
    drive_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      drive_d[i] = wave_q & (src_q == SRC_W'(i));
    end
  end

  always_comb begin
    cnt_d = clr_cnt ? '0 : cnt_q + CNT_W'(fall);
  end

  assign drive     = drive_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_cell_stim_gen.sv
// Randomised bench for cell_stim_gen against closed-form waveform model.
// Checks drive/busy/done/pulse_cnt cycle by cycle per scenario.
module tb_cell_stim_gen;

  localparam int CH = 8;
  localparam int SW = 4;
  localparam int DW = 3;
  localparam int BW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          trigger = 1'b0;
  logic [DW-1:0] div = '0;
  logic [SW-1:0] source = '0;
  logic [BW-1:0] burst_len = '0;
  logic          clr_cnt = 1'b0;
  logic [CH-1:0] drive;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulse_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  cell_stim_gen #(
    .CHANNELS(CH),
    .SRC_W   (SW),
    .DIV_W   (DW),
    .BURST_W (BW),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .trigger  (trigger),
    .div      (div),
    .source   (source),
    .burst_len(burst_len),
    .clr_cnt  (clr_cnt),
    .drive    (drive),
    .busy     (busy),
    .done     (done),
    .pulse_cnt(pulse_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wave level j edges after run entry, half-period n.
  function automatic logic wave_at(input int j, input int n);
    return ((j / n) % 2) == 1;
  endfunction

  function automatic logic [CH-1:0] sel(input logic w, input int s);
    logic [CH-1:0] one;
    one = CH'(1);
    return (w && s < CH) ? (one << s) : '0;
  endfunction

  task automatic chk_outs(input string tag, input logic [CH-1:0] d,
                          input logic b, input logic dn);
    check({tag, "_drive"}, 32'(drive), 32'(d));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(dn));
  endtask

  task automatic run_cont(input int d, input int s);
    int n;
    int w;
    logic [CW-1:0] base;
    n = 1 << d;
    w = 8 * n + 3;
    base = exp_cnt;
    div = DW'(d);
    source = SW'(s);
    mode = 2'd1;
    step();
    check("cont_entry_busy", 32'(busy), 1);
    for (int m = 1; m <= w; m++) begin
      step();
      if (m == 2) begin
        div = DW'($urandom);
        source = SW'($urandom);
      end
      chk_outs("cont", sel(wave_at(m - 1, n), s), 1'b1, 1'b0);
      check("cont_cnt", 32'(pulse_cnt), 32'(base + CW'(m / (2 * n))));
    end
    exp_cnt = base + CW'(w / (2 * n)) + CW'(wave_at(w, n));
    mode = 2'd0;
    step();
    check("off_busy", 32'(busy), 0);
    check("off_done", 32'(done), 0);
    check("off_cnt", 32'(pulse_cnt), 32'(exp_cnt));
    step();
    chk_outs("off_after", '0, 1'b0, 1'b0);
  endtask

  task automatic run_burst(input int d, input int s, input int l);
    int n;
    int t;
    logic [CW-1:0] base;
    n = 1 << d;
    t = 2 * n * l;
    base = exp_cnt;
    div = DW'(d);
    source = SW'(s);
    burst_len = BW'(l);
    mode = 2'd2;
    step();
    step();
    check("bst_wait_busy", 32'(busy), 0);
    trigger = 1'b1;
    step();
    step();
    trigger = 1'b0;
    step();
    check("bst_entry_busy", 32'(busy), 1);
    for (int m = 1; m <= t + 1; m++) begin
      step();
      if (m == 1) trigger = 1'b1;
      if (m == 3) trigger = 1'b0;
      if (m == 2) begin
        div = DW'($urandom);
        source = SW'($urandom);
        burst_len = BW'($urandom);
      end
      chk_outs("bst", sel(wave_at(m - 1, n), s), m < t, m == t);
      check("bst_cnt", 32'(pulse_cnt), 32'(base + CW'(m / (2 * n))));
    end
    exp_cnt = base + CW'(l);
    repeat (3) begin
      step();
      chk_outs("bst_idle", '0, 1'b0, 1'b0);
    end
    mode = 2'd0;
    step();
    check("bst_end_cnt", 32'(pulse_cnt), 32'(exp_cnt));
  endtask

  task automatic run_zero();
    burst_len = '0;
    source = SW'(2);
    mode = 2'd2;
    step();
    trigger = 1'b1;
    step();
    step();
    trigger = 1'b0;
    step();
    chk_outs("zero_done", '0, 1'b0, 1'b1);
    for (int m = 1; m <= 4; m++) begin
      step();
      chk_outs("zero_after", '0, 1'b0, 1'b0);
    end
    check("zero_cnt", 32'(pulse_cnt), 32'(exp_cnt));
    mode = 2'd0;
    step();
  endtask

  task automatic run_step(input int s, input int ne);
    logic w;
    w = 1'b0;
    mode = 2'd3;
    source = SW'(s);
    step();
    for (int e = 0; e < ne; e++) begin
      trigger = 1'b1;
      for (int m = 1; m <= 10; m++) begin
        step();
        if (m == 2) trigger = 1'b0;
        chk_outs("step", sel((m >= 4) ? ~w : w, s), 1'b0, 1'b0);
      end
      if (w) exp_cnt = exp_cnt + CW'(1);
      w = ~w;
      check("step_cnt", 32'(pulse_cnt), 32'(exp_cnt));
    end
    mode = 2'd0;
    step();
    if (w) exp_cnt = exp_cnt + CW'(1);
    check("step_leave_cnt", 32'(pulse_cnt), 32'(exp_cnt));
    step();
    chk_outs("step_leave", '0, 1'b0, 1'b0);
  endtask

  task automatic run_oor();
    logic [CW-1:0] base;
    base = exp_cnt;
    div = '0;
    source = SW'(9);
    mode = 2'd1;
    step();
    for (int m = 1; m <= 12; m++) begin
      step();
      chk_outs("oor", '0, 1'b1, 1'b0);
      check("oor_cnt", 32'(pulse_cnt), 32'(base + CW'(m / 2)));
    end
    exp_cnt = base + CW'(6);
    mode = 2'd0;
    step();
    check("oor_off_cnt", 32'(pulse_cnt), 32'(exp_cnt));
    step();
  endtask

  task automatic run_clr_rst();
    div = '0;
    source = SW'(3);
    burst_len = BW'(4);
    mode = 2'd2;
    step();
    trigger = 1'b1;
    step();
    step();
    trigger = 1'b0;
    step();
    step();
    check("clr_pre_cnt", 32'(pulse_cnt), 32'(exp_cnt));
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_vs_inc", 32'(pulse_cnt), 0);
    step();
    step();
    check("clr_then_inc", 32'(pulse_cnt), 1);
    step();
    check("rst_mid_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("rst_now", '0, 1'b0, 1'b0);
    check("rst_now_cnt", 32'(pulse_cnt), 0);
    exp_cnt = '0;
    repeat (3) begin
      step();
      chk_outs("rst_hold", '0, 1'b0, 1'b0);
    end
    mode = 2'd0;
    rst = 1'b0;
    repeat (4) begin
      step();
      chk_outs("rst_after", '0, 1'b0, 1'b0);
      check("rst_after_cnt", 32'(pulse_cnt), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk_outs("reset", '0, 1'b0, 1'b0);
    check("reset_cnt", 32'(pulse_cnt), 0);
    rst = 1'b0;
    step();
    chk_outs("reset_rel", '0, 1'b0, 1'b0);
    check("reset_rel_cnt", 32'(pulse_cnt), 0);

    run_cont(0, 2);
    repeat (3) run_cont($urandom_range(0, 2), $urandom_range(0, 7));
    run_burst(2, 5, 3);
    repeat (3) begin
      run_burst($urandom_range(1, 2), $urandom_range(0, 7),
                $urandom_range(2, 4));
    end
    run_zero();
    run_step(7, 4);
    repeat (2) run_step($urandom_range(0, 7), $urandom_range(3, 6));
    run_cont(0, 1);
    run_oor();
    run_clr_rst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
